// File: rtl/iob_cache_write_through_buffer_pkg.sv
// Shared types and width helpers for the write-through buffer.
// Replaces the NBYTES/NBYTES_W macros of the shared cache header.
package iob_cache_write_through_buffer_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } wtb_state_t;

  function automatic int unsigned wtb_nbytes(input int unsigned data_w);
    return data_w / 8;
  endfunction

  function automatic int unsigned wtb_nbytes_w(input int unsigned data_w);
    return $clog2(data_w / 8);
  endfunction

endpackage

// File: rtl/iob_cache_write_through_buffer_if.sv
// Front-end push port and back-end write channel of the write-through buffer.
interface iob_cache_write_through_buffer_if
  import iob_cache_write_through_buffer_pkg::*;
#(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32
);
  localparam int unsigned NBYTES   = wtb_nbytes(DATA_W);
  localparam int unsigned NBYTES_W = wtb_nbytes_w(DATA_W);

  logic                       push;
  logic [ADDR_W-NBYTES_W-1:0] push_addr;
  logic [DATA_W-1:0]          push_wdata;
  logic [NBYTES-1:0]          push_wstrb;
  logic                       full;
  logic                       empty;
  logic                       out_valid;
  logic [ADDR_W-NBYTES_W-1:0] out_addr;
  logic [DATA_W-1:0]          out_wdata;
  logic [NBYTES-1:0]          out_wstrb;
  logic                       out_ready;

  modport master (
    output push, push_addr, push_wdata, push_wstrb, out_ready,
    input  full, empty, out_valid, out_addr, out_wdata, out_wstrb
  );

  modport slave (
    input  push, push_addr, push_wdata, push_wstrb, out_ready,
    output full, empty, out_valid, out_addr, out_wdata, out_wstrb
  );

endinterface

// File: rtl/iob_cache_write_through_buffer_fifo.sv
// Circular store of pending word writes; head entry is read combinationally.
module iob_cache_wtb_fifo
  import iob_cache_write_through_buffer_pkg::*;
#(
  parameter int unsigned ADDR_W  = 32,
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned DEPTH_W = 2
) (
  input  logic                                     clk,
  input  logic                                     reset,
  input  logic                                     push,
  input  logic [ADDR_W-wtb_nbytes_w(DATA_W)-1:0]   push_addr,
  input  logic [DATA_W-1:0]                        push_wdata,
  input  logic [wtb_nbytes(DATA_W)-1:0]            push_wstrb,
  input  logic                                     pop,
  output logic                                     push_accepted,
  output logic                                     full,
  output logic [DEPTH_W:0]                         level,
  output logic [ADDR_W-wtb_nbytes_w(DATA_W)-1:0]   out_addr,
  output logic [DATA_W-1:0]                        out_wdata,
  output logic [wtb_nbytes(DATA_W)-1:0]            out_wstrb
);
  localparam int unsigned NBYTES   = wtb_nbytes(DATA_W);
  localparam int unsigned NBYTES_W = wtb_nbytes_w(DATA_W);
  localparam int unsigned WORD_W   = ADDR_W - NBYTES_W;
  localparam int unsigned DEPTH    = 2 ** DEPTH_W;
  localparam int unsigned CNT_W    = DEPTH_W + 1;

  logic [WORD_W-1:0] addr_mem  [DEPTH];
  logic [DATA_W-1:0] wdata_mem [DEPTH];
  logic [NBYTES-1:0] wstrb_mem [DEPTH];

  logic [DEPTH_W-1:0] wr_ptr;
  logic [DEPTH_W-1:0] rd_ptr;
  logic [CNT_W-1:0]   count;

  // full is taken from the registered count, so a same-cycle pop never frees room
  assign full          = (count == CNT_W'(DEPTH));
  assign push_accepted = push & ~full;
  assign level         = count;

  assign out_addr  = addr_mem[rd_ptr];
  assign out_wdata = wdata_mem[rd_ptr];
  assign out_wstrb = wstrb_mem[rd_ptr];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        addr_mem[i]  <= '0;
        wdata_mem[i] <= '0;
        wstrb_mem[i] <= '0;
      end
    end else if (push_accepted) begin
      addr_mem[wr_ptr]  <= push_addr;
      wdata_mem[wr_ptr] <= push_wdata;
      wstrb_mem[wr_ptr] <= push_wstrb;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_accepted) wr_ptr <= wr_ptr + 1'b1;
      if (pop)           rd_ptr <= rd_ptr + 1'b1;
      count <= count + CNT_W'(push_accepted) - CNT_W'(pop);
    end
  end

endmodule

// File: rtl/iob_cache_write_through_buffer.sv
// Write-through buffer: queues front-end stores and drains them in order
// into the back-end write channel, holding the head until completion.
module iob_cache_write_through_buffer
  import iob_cache_write_through_buffer_pkg::*;
#(
  parameter int unsigned ADDR_W  = 32,
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned DEPTH_W = 2
) (
  input logic                               clk,
  input logic                               reset,
  iob_cache_write_through_buffer_if.slave   bus
);
  localparam int unsigned CNT_W = DEPTH_W + 1;

  wtb_state_t       state;
  wtb_state_t       state_nxt;
  logic [CNT_W-1:0] level;
  logic [CNT_W-1:0] count_after_pop;
  logic             push_accepted;
  logic             pop;
  logic             full;
  logic             out_valid;

  iob_cache_wtb_fifo #(
    .ADDR_W  (ADDR_W),
    .DATA_W  (DATA_W),
    .DEPTH_W (DEPTH_W)
  ) fifo (
    .clk           (clk),
    .reset         (reset),
    .push          (bus.push),
    .push_addr     (bus.push_addr),
    .push_wdata    (bus.push_wdata),
    .push_wstrb    (bus.push_wstrb),
    .pop           (pop),
    .push_accepted (push_accepted),
    .full          (full),
    .level         (level),
    .out_addr      (bus.out_addr),
    .out_wdata     (bus.out_wdata),
    .out_wstrb     (bus.out_wstrb)
  );

  assign bus.full      = full;
  assign bus.out_valid = out_valid;
  assign bus.empty     = (level == '0) && (state == IDLE);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // In BUSY the channel is already working on the head; valid tells it
  // whether another entry follows the one completing this cycle.
  always_comb begin
    state_nxt       = state;
    pop             = 1'b0;
    out_valid       = 1'b0;
    count_after_pop = level - CNT_W'(bus.out_ready) + CNT_W'(push_accepted);
    unique case (state)
      IDLE: begin
        out_valid = (level != '0);
        if (out_valid && bus.out_ready) state_nxt = BUSY;
      end
      BUSY: begin
        out_valid = (count_after_pop != '0);
        pop       = bus.out_ready;
        if (count_after_pop == '0) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

endmodule
